// File: rtl/la_ioinput_ctrl.sv
// la_ioinput_ctrl: staggered input-enable sequencing plus resync/debounce of input pad levels
// clk, nreset      core clock, async active-low reset
// en               1 brings the bank up and keeps it up, 0 shuts it down
// db_thresh        debounce threshold, 0 behaves as 1
// z                raw pad levels, asynchronous to clk
// ie               per-cell input enables, raised one at a time
// ready            bank fully enabled and settled
// dout, rise, fall debounced levels with one-cycle edge pulses
module la_ioinput_ctrl #(
  parameter int N = 8,
  parameter int STAGGER = 4,
  parameter int DEBW = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            en,
  input  logic [DEBW-1:0] db_thresh,
  input  logic [N-1:0]    z,
  output logic [N-1:0]    ie,
  output logic            ready,
  output logic [N-1:0]    dout,
  output logic [N-1:0]    rise,
  output logic [N-1:0]    fall
);
  typedef enum logic [1:0] {IDLE, ENABLE, SETTLE, ACTIVE} state_t;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int SW = STAGGER > 1 ? $clog2(STAGGER) : 1;
  state_t state, state_n;
  logic [N-1:0] ie_n, s1, s2;
  logic [IW-1:0] idx, idx_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [DEBW-1:0] cnt [N];
  logic [DEBW:0] inc [N];
  logic [DEBW:0] t;
  logic step, clr;
  assign step = scnt == SW'(STAGGER - 1);
  // shutdown edge: everything downstream of the enables is wiped together
  assign clr = (state != IDLE) && !en;
  assign t = db_thresh == '0 ? (DEBW + 1)'(1) : {1'b0, db_thresh};
  assign ready = state == ACTIVE;
  always_comb begin
    state_n = state;
    ie_n = ie;
    idx_n = idx;
    scnt_n = scnt;
    if (clr) begin
      state_n = IDLE;
      ie_n = '0;
      idx_n = '0;
      scnt_n = '0;
    end else begin
      case (state)
        IDLE: if (en) begin
          ie_n[0] = 1'b1;
          idx_n = IW'(1);
          scnt_n = '0;
          state_n = N == 1 ? SETTLE : ENABLE;
        end
        ENABLE: begin
          scnt_n = step ? '0 : scnt + 1'b1;
          if (step) begin
            ie_n[idx] = 1'b1;
            idx_n = idx + 1'b1;
            if (idx == IW'(N - 1)) state_n = SETTLE;
          end
        end
        SETTLE: begin
          scnt_n = step ? '0 : scnt + 1'b1;
          if (step) state_n = ACTIVE;
        end
        default: state_n = state;
      endcase
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      ie <= '0;
      idx <= '0;
      scnt <= '0;
    end else begin
      state <= state_n;
      ie <= ie_n;
      idx <= idx_n;
      scnt <= scnt_n;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= clr ? '0 : z;
      s2 <= clr ? '0 : s1;
    end
  end
  always_comb begin
    for (int i = 0; i < N; i++) inc[i] = {1'b0, cnt[i]} + 1'b1;
  end
  // count compares against the live threshold, so a lowered T can release at once
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      dout <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (clr || !ie[i]) begin
          dout[i] <= 1'b0;
          cnt[i] <= '0;
        end else if (s2[i] == dout[i]) begin
          cnt[i] <= '0;
        end else if (inc[i] >= t) begin
          dout[i] <= s2[i];
          cnt[i] <= '0;
          rise[i] <= s2[i];
          fall[i] <= !s2[i];
        end else begin
          cnt[i] <= inc[i][DEBW-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_la_ioinput_ctrl.sv
// tb_la_ioinput_ctrl: scoreboarded directed bench for la_ioinput_ctrl (N=4, STAGGER=4, DEBW=4)
module tb_la_ioinput_ctrl;
  typedef struct {
    int cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] dout;
  } ev_t;
  logic clk = 1'b0;
  logic nreset, en;
  logic [3:0] db_thresh, z, ie, dout, rise, fall;
  logic ready;
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  ev_t q[$];
  ev_t e;
  la_ioinput_ctrl #(.N(4), .STAGGER(4), .DEBW(4)) dut (
    .clk(clk),
    .nreset(nreset),
    .en(en),
    .db_thresh(db_thresh),
    .z(z),
    .ie(ie),
    .ready(ready),
    .dout(dout),
    .rise(rise),
    .fall(fall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic ev_t mk(input int c, input logic [3:0] r, f, d);
    ev_t x;
    x.cyc = c;
    x.rise = r;
    x.fall = f;
    x.dout = d;
    return x;
  endfunction
  always @(negedge clk) begin
    if ((rise | fall) != 4'b0) begin
      checks++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_pulse: cyc=%0d rise=%b fall=%b dout=%b, required no pulse", cyc, rise, fall, dout);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.rise !== rise || e.fall !== fall || e.dout !== dout) begin
          errs++;
          $display("FAIL pulse_event: got cyc=%0d rise=%b fall=%b dout=%b, required cyc=%0d rise=%b fall=%b dout=%b",
                   cyc, rise, fall, dout, e.cyc, e.rise, e.fall, e.dout);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h at cyc %0d", nm, got, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bringup();
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      chk("bringup_ie", ie, k >= 13 ? 4'hf : k >= 9 ? 4'h7 : k >= 5 ? 4'h3 : 4'h1);
      chk("bringup_ready", ready, k >= 17 ? 1 : 0);
    end
  endtask
  initial begin
    nreset = 1'b1;
    en = 1'b0;
    z = 4'h0;
    db_thresh = 4'd3;
    #1 nreset = 1'b0;
    #11;
    chk("reset_ie", ie, 0);
    chk("reset_ready", ready, 0);
    chk("reset_dout", dout, 0);
    chk("reset_pulses", {rise, fall}, 0);
    @(posedge clk);
    #1 nreset = 1'b1;
    tick(2);
    chk("idle_hold_ie", ie, 0);
    en = 1'b1;
    bringup();
    z[0] = 1'b1;
    q.push_back(mk(cyc + 5, 4'b0001, 4'b0000, 4'b0001));
    tick(8);
    chk("deb_rise_dout", dout, 4'b0001);
    z[0] = 1'b0;
    q.push_back(mk(cyc + 5, 4'b0000, 4'b0001, 4'b0000));
    tick(8);
    chk("deb_fall_dout", dout, 4'b0000);
    z[1] = 1'b1;
    tick(2);
    z[1] = 1'b0;
    tick(6);
    chk("glitch_dout", dout, 4'b0000);
    db_thresh = 4'd0;
    z[2] = 1'b1;
    q.push_back(mk(cyc + 3, 4'b0100, 4'b0000, 4'b0100));
    tick(4);
    chk("t0_dout", dout, 4'b0100);
    db_thresh = 4'd3;
    en = 1'b0;
    tick(1);
    chk("shutdown_ie", ie, 0);
    chk("shutdown_ready", ready, 0);
    chk("shutdown_dout", dout, 0);
    chk("shutdown_pulses", {rise, fall}, 0);
    tick(2);
    en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      chk("restart_ie", ie, k >= 5 ? 4'h3 : 4'h1);
    end
    en = 1'b0;
    tick(1);
    chk("midenable_ie", ie, 0);
    chk("midenable_ready", ready, 0);
    chk("midenable_dout", dout, 0);
    tick(2);
    en = 1'b1;
    q.push_back(mk(cyc + 12, 4'b0100, 4'b0000, 4'b0100));
    bringup();
    chk("high_at_enable_dout", dout, 4'b0100);
    z = 4'hf;
    q.push_back(mk(cyc + 5, 4'b1011, 4'b0000, 4'b1111));
    tick(8);
    chk("all_high_dout", dout, 4'hf);
    #2 nreset = 1'b0;
    #1;
    chk("async_ie", ie, 0);
    chk("async_ready", ready, 0);
    chk("async_dout", dout, 0);
    chk("async_pulses", {rise, fall}, 0);
    z = 4'h0;
    @(posedge clk);
    #1 nreset = 1'b1;
    bringup();
    tick(2);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
